// File: rtl/riscv_mem_pkg.sv
// Shared constants for the instruction/data memory arbiter: owner ids, FSM states, default widths.
// No logic here; imported by the arbiter and its round-robin picker.
// Byte-enable constant is wide enough to slice for any data width up to 128 bits.
package riscv_mem_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam int              BE_MAX = 16;
    localparam logic [BE_MAX-1:0] BE_ALL = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever did not win last.
// Latency: combinational. Backpressure: none, the caller decides when a pick is consumed.
// Bit 0 of req/grant is the IF port, bit 1 the D port.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = OWN_IF;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = OWN_IF;
            2'b10:   winner = OWN_D;
            2'b11:   winner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
            default: winner = OWN_IF;
        endcase
        if (|req) begin
            grant = (winner == OWN_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Latency: gnt one cycle after req, rvalid one cycle after mem_ack (2 cycles minimum per access).
// Backpressure: losers hold req until gnt; core_stall freezes the datapath while anything is pending.
module imem_dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                core_stall
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    arb_state_t       state, state_nxt;
    logic             owner, last_owner;
    logic             if_pend, d_pend;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       arb_grant;
    logic             arb_winner;
    logic             start, done, timed_out;
    mem_cmd_t         cmd_nxt;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, if_req}),
        .last_owner (last_owner),
        .grant      (arb_grant),
        .winner     (arb_winner)
    );

    always_comb begin
        state_nxt     = state;
        start         = 1'b0;
        done          = 1'b0;
        timed_out     = 1'b0;
        cmd_nxt.we    = 1'b0;
        cmd_nxt.be    = BE_ALL[BE_W-1:0];
        cmd_nxt.addr  = if_addr;
        cmd_nxt.wdata = '0;
        if (arb_winner == OWN_D) begin
            cmd_nxt.we    = d_we;
            cmd_nxt.be    = d_be;
            cmd_nxt.addr  = d_addr;
            cmd_nxt.wdata = d_wdata;
        end
        case (state)
            IDLE: begin
                if (|arb_grant) begin
                    start     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // an ack landing on the timeout cycle still counts as success
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_D;
            last_owner <= OWN_D;
            if_pend    <= 1'b0;
            d_pend     <= 1'b0;
            cnt        <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (start) begin
                mem_req    <= 1'b1;
                mem_we     <= cmd_nxt.we;
                mem_be     <= cmd_nxt.be;
                mem_addr   <= cmd_nxt.addr;
                mem_wdata  <= cmd_nxt.wdata;
                owner      <= arb_winner;
                last_owner <= arb_winner;
                if_pend    <= arb_grant[0];
                d_pend     <= arb_grant[1];
                if_gnt     <= arb_grant[0];
                d_gnt      <= arb_grant[1];
                // cnt holds the 1-based index of the current WAIT cycle
                cnt        <= CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (done) begin
                mem_req   <= 1'b0;
                if_pend   <= 1'b0;
                d_pend    <= 1'b0;
                cnt       <= '0;
                rdata     <= (timed_out || mem_we) ? '0 : mem_rdata;
                err       <= timed_out;
                if_rvalid <= (owner == OWN_IF);
                d_rvalid  <= (owner == OWN_D);
            end
        end
    end

    assign core_stall = ((if_req | if_pend) & ~if_rvalid) | ((d_req | d_pend) & ~d_rvalid);

endmodule
